// File: rtl/abc_sweep_pkg.sv
// abc_sweep_pkg: shared types and helpers for the truth-table sweep.
// Holds the FSM state enum, vector type and lowest-set-bit helper.
package abc_sweep_pkg;

  localparam int NUM_VEC = 8;

  typedef logic [2:0] vec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Index of the lowest set bit; 0 when v is all zero.
  function automatic vec_t lowest_set(input logic [NUM_VEC-1:0] v);
    vec_t r;
    r = '0;
    for (int i = NUM_VEC - 1; i >= 0; i--) begin
      if (v[i]) r = vec_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/abc_sweep_ctrl_settle_timer.sv
// settle_timer: counts SETTLE cycles while i_clear is low.
// Ports: clk, reset_n, i_clear (hold count at 0), o_expire (pulse).
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  output logic o_expire
);

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  logic [3:0] r_cnt;
  logic       w_expire;

  // Fires in the SETTLE-th cycle after i_clear drops.
  assign w_expire = !i_clear && (r_cnt == LAST);
  assign o_expire = w_expire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear || w_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/abc_sweep_ctrl.sv
// abc_sweep_ctrl: drives {a,b,c}=0..7 into a FUT, samples y per vector,
// compares the captured table against a latched expected mask.
// Ports: clk, reset_n; i_start, i_abort, i_expected[7:0], i_y in;
//        o_a/o_b/o_c, o_busy, o_done, o_table, o_mismatch, o_pass,
//        o_first_fail[2:0], o_fail_valid out.
module abc_sweep_ctrl
  import abc_sweep_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [NUM_VEC-1:0] i_expected,
  input  logic               i_y,
  output logic               o_a,
  output logic               o_b,
  output logic               o_c,
  output logic               o_busy,
  output logic               o_done,
  output logic [NUM_VEC-1:0] o_table,
  output logic [NUM_VEC-1:0] o_mismatch,
  output logic               o_pass,
  output vec_t               o_first_fail,
  output logic               o_fail_valid
);

  state_t             r_state;
  vec_t               r_idx;
  logic [NUM_VEC-1:0] r_exp;
  logic [NUM_VEC-1:0] r_table;
  logic [NUM_VEC-1:0] r_mm;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  vec_t               r_ff;
  logic               r_fv;

  logic               w_clear;
  logic               w_expire;
  logic [NUM_VEC-1:0] w_table;
  logic [NUM_VEC-1:0] w_mm;

  assign w_clear = (r_state != ST_SETTLE);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_clear),
    .o_expire (w_expire)
  );

  // Table including the bit captured on this edge, so the final
  // compare sees vector 7 without an extra cycle.
  always_comb begin
    w_table        = r_table;
    w_table[r_idx] = i_y;
  end

  assign w_mm = w_table ^ r_exp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_exp   <= '0;
      r_table <= '0;
      r_mm    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_ff    <= '0;
      r_fv    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != ST_IDLE && i_abort) begin
        r_state <= ST_IDLE;
        r_idx   <= '0;
        r_busy  <= 1'b0;
        r_pass  <= 1'b0;
        r_fv    <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (i_start && !i_abort) begin
              r_state <= ST_SETTLE;
              r_idx   <= '0;
              r_exp   <= i_expected;
              r_table <= '0;
              r_mm    <= '0;
              r_busy  <= 1'b1;
              r_pass  <= 1'b0;
              r_ff    <= '0;
              r_fv    <= 1'b0;
            end
          end
          ST_SETTLE: begin
            if (w_expire) r_state <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            r_table <= w_table;
            if (r_idx == vec_t'(NUM_VEC - 1)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_mm    <= w_mm;
              r_pass  <= (w_mm == '0);
              r_ff    <= lowest_set(w_mm);
              r_fv    <= |w_mm;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= ST_SETTLE;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_a          = r_idx[2];
  assign o_b          = r_idx[1];
  assign o_c          = r_idx[0];
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_table      = r_table;
  assign o_mismatch   = r_mm;
  assign o_pass       = r_pass;
  assign o_first_fail = r_ff;
  assign o_fail_valid = r_fv;

endmodule

// File: doc/abc_sweep_ctrl.md
# abc_sweep_ctrl

Sequencing controller for the three-input function-under-test (FUT) block with inputs A, B, C and output Y. On request it drives all eight input vectors {A,B,C} = 0..7 in ascending order. For each vector it waits a programmable settle time, then samples Y to build an 8-bit captured truth table. It compares that table against an expected mask latched at start and reports pass/fail plus the lowest failing vector. It sits between the lab top level (switches/buttons/LEDs) and the combinational FUT.

## Interface
- SETTLE, default 2: cycles each vector is held before Y is sampled; legal range 1..15.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; accepted only in IDLE.
- abort  in  1  level; terminates a sweep in progress.
- expected  in  8  expected truth table, bit i = Y for {A,B,C}=i; latched on start acceptance.
- y  in  1  FUT output.
- a, b, c  out  1 each  FUT inputs; a = MSB of vector index.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse on sweep completion.
- table  out  8  captured Y values, bit i from vector i.
- mismatch  out  8  table XOR latched expected; valid from done onward.
- pass  out  1  mismatch == 0; valid from done onward.
- first_fail  out  3  lowest set bit of mismatch; 0 when none.
- fail_valid  out  1  mismatch ≠ 0.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 and abort=0 → latch expected, clear table, set idx=0, go to SETTLE.
- SETTLE: counter runs 0..SETTLE-1; at the last count → SAMPLE.
- SAMPLE: table[idx] ← y.
  - If idx<7: idx+1, go to SETTLE.
  - If idx=7: go to DONE.
- DONE: done=1, and mismatch/pass/first_fail/fail_valid are registered; → IDLE.
- {a,b,c} = idx at all times, so a change of vector takes effect on the edge leaving SAMPLE.
- abort=1 in any non-IDLE state → IDLE on the next edge.
  - No done pulse.
  - pass=0 and fail_valid=0.
  - table keeps the partial capture.
  - {a,b,c}=000.
- abort has priority over start and over every state transition.
- start while busy is ignored; there is no queueing.
- start held high → back-to-back sweeps with exactly one IDLE cycle between them.
- Result outputs hold until the next accepted start, which clears table, mismatch, pass, first_fail and fail_valid.

## Timing
- Reset (async assert, sync release):
  - State=IDLE, idx=0, counter=0.
  - a=b=c=0, busy=0, done=0.
  - table=0, mismatch=0, pass=0, first_fail=0, fail_valid=0.
  - Latched expected=0.
- Reset asserted mid-sweep: all of the above take effect immediately, without waiting for a clock edge.
- Start accepted at edge k:
  - busy=1 from k; vector 0 is driven.
  - Vector i is sampled at edge k+(i+1)(SETTLE+1).
  - done is high in the cycle after edge k+8(SETTLE+1), i.e. 8·(SETTLE+1) cycles after acceptance.
  - busy is still high during the done cycle and drops at the following edge.
- Y is required to settle within SETTLE cycles; the FUT is purely combinational, so SETTLE=1 suffices in simulation.

## Structure
- Package abc_sweep_pkg holds:
  - state_t enum (IDLE, SETTLE, SAMPLE, DONE).
  - localparam NUM_VEC=8.
  - typedef vec_t = logic [2:0].
  - Function lowest_set(logic [7:0]) → vec_t.
- One sub-module: settle_timer.
  - Inputs: clk, reset_n, clear.
  - Output: expire, a one-cycle pulse after SETTLE cycles.
  - Parameterised by SETTLE.
- The FUT is instantiated by the bench or top level, not inside this block.

## Test plan
- Reset: drive reset_n=0 mid-cycle → all outputs 0 immediately; state IDLE after release.
- Golden sweep: FUT Y=(A′+B′C)′·(A′+B′C′)′ (reduces to A·B), SETTLE=2, expected=8'hC0 → done 24 cycles after acceptance; table=8'hC0, mismatch=0, pass=1, fail_valid=0.
- Faulty FUT Y=A, expected=8'hC0 → table=8'hF0, mismatch=8'h30, first_fail=4, fail_valid=1, pass=0.
- Abort: assert abort while idx=3 → busy=0 next edge, no done pulse, table[2:0] captured, {a,b,c}=000, pass=0.
- Start while busy, then start held high continuously → mid-sweep start is ignored and the expected mask is unchanged; two consecutive sweeps separated by exactly one IDLE cycle.
- SETTLE=1 corner: golden FUT → done 16 cycles after acceptance, table=8'hC0; simultaneous start+abort in IDLE → no sweep begins.
